// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory target; one request at a time over req valid/ready, access after LATENCY cycles, response over resp valid/ready, busy and completed-transaction count
module data_mem_responder #(
  parameter int MEM_WORDS = 65536,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] txn_count
);
  localparam int ADDR_BITS = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [MEM_WORDS];
  logic acc, a_we, in_range;
  logic [31:0] a_addr, a_wdata;
  logic [ADDR_BITS-1:0] idx;
  always_comb begin
    a_we = state == IDLE ? req_we : we_q;
    a_addr = state == IDLE ? req_addr : addr_q;
    a_wdata = state == IDLE ? req_wdata : wdata_q;
    acc = state == IDLE ? req_valid && req_ready && LATENCY == 1 : state == WAIT && cnt == 4'd1;
    in_range = a_addr < 32'(MEM_WORDS);
    idx = a_addr[ADDR_BITS-1:0];
  end
  always_ff @(posedge clk)
    if (!rst && acc && a_we && in_range) mem[idx] <= a_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      busy <= 1'b0;
      txn_count <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && req_ready) begin
          we_q <= req_we;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          cnt <= 4'(LATENCY - 1);
          req_ready <= 1'b0;
          busy <= 1'b1;
          state <= LATENCY == 1 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          state <= cnt == 4'd1 ? RESP : WAIT;
        end
        RESP: if (resp_ready) begin
          txn_count <= txn_count + 32'd1;
          resp_valid <= 1'b0;
          resp_err <= 1'b0;
          req_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (acc) begin
        resp_valid <= 1'b1;
        resp_rdata <= in_range && !a_we ? mem[idx] : '0;
        resp_err <= !in_range;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a LATENCY=2 and a LATENCY=1 responder sharing one request bus
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic sel = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] rr, rv, re, bz;
  logic [31:0] rd [2];
  logic [31:0] tc [2];
  logic rr_m, rv_m, re_m, bz_m;
  logic [31:0] rd_m, tc_m;
  int errors = 0, checks = 0, exp_txn = 0, cyc = 0;
  logic [31:0] vals [5] = '{32'd5, 32'd3, 32'd4, 32'd1, 32'd2};

  data_mem_responder #(.MEM_WORDS(65536), .LATENCY(2)) dut (
    .clk(clk), .rst(rst0), .req_valid(req_valid), .req_ready(rr[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[0]), .resp_ready(resp_ready),
    .resp_rdata(rd[0]), .resp_err(re[0]), .busy(bz[0]), .txn_count(tc[0]));

  data_mem_responder #(.MEM_WORDS(65536), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid), .req_ready(rr[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[1]), .resp_ready(resp_ready),
    .resp_rdata(rd[1]), .resp_err(re[1]), .busy(bz[1]), .txn_count(tc[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rr_m = rr[sel];
    rv_m = rv[sel];
    re_m = re[sel];
    bz_m = bz[sel];
    rd_m = rd[sel];
    tc_m = tc[sel];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_er, input int hold);
    int n, lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!rr_m && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(rr_m), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = 32'd5; req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    while (!rv_m && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd2);
    check({tag, "_busy"}, 32'(bz_m), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(rv_m), 32'd1);
      check({tag, "_hold_rdata"}, rd_m, exp_rd);
      check({tag, "_hold_rready"}, 32'(rr_m), 32'd0);
      @(negedge clk);
    end
    check({tag, "_rdata"}, rd_m, exp_rd);
    check({tag, "_err"}, 32'(re_m), 32'(exp_er));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_txn++;
    check({tag, "_post_valid"}, 32'(rv_m), 32'd0);
    check({tag, "_post_busy"}, 32'(bz_m), 32'd0);
    check({tag, "_post_err"}, 32'(re_m), 32'd0);
    check({tag, "_post_rdata"}, rd_m, exp_rd);
    check({tag, "_txn"}, tc_m, 32'(exp_txn));
  endtask

  initial begin
    int n, acc_prev;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    check("rst_req_ready", 32'(rr_m), 32'd1);
    check("rst_resp_valid", 32'(rv_m), 32'd0);
    check("rst_busy", 32'(bz_m), 32'd0);
    check("rst_txn", tc_m, 32'd0);
    check("rst_rdata", rd_m, 32'd0);
    check("rst_err", 32'(re_m), 32'd0);
    txn("st10", 1'b1, 32'd10, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    txn("ld10", 1'b0, 32'd10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
    check("txn_two", tc_m, 32'd2);
    txn("ld10_bp", 1'b0, 32'd10, 32'd0, 32'hDEAD_BEEF, 1'b0, 5);
    txn("st0", 1'b1, 32'd0, 32'h55, 32'd0, 1'b0, 0);
    txn("st_oor", 1'b1, 32'd65536, 32'h1234, 32'd0, 1'b1, 0);
    txn("ld0_a", 1'b0, 32'd0, 32'd0, 32'h55, 1'b0, 0);
    txn("st_hi", 1'b1, 32'hFFFF_0000, 32'h9999, 32'd0, 1'b1, 0);
    txn("ld_oor", 1'b0, 32'd65536, 32'd0, 32'd0, 1'b1, 0);
    txn("ld0_b", 1'b0, 32'd0, 32'd0, 32'h55, 1'b0, 0);
    txn("st_top", 1'b1, 32'd65535, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
    txn("ld_top", 1'b0, 32'd65535, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
    for (int k = 0; k < 3; k++) txn("st_h", 1'b1, 32'(3 + k), 32'(32'h300 + k), 32'd0, 1'b0, 0);
    // held request: valid stays high, live address switches to 10 right after each acceptance
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; resp_ready = 1'b1;
    acc_prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!rr_m && n < 20) begin @(negedge clk); n++; end
      check("held_ready", 32'(rr_m), 32'd1);
      if (k > 0) check("held_interval", 32'(cyc + 1 - acc_prev), 32'd3);
      acc_prev = cyc + 1;
      req_addr = 32'(3 + k);
      @(negedge clk);
      req_addr = 32'd10;
      n = 0;
      while (!rv_m && n < 20) begin @(negedge clk); n++; end
      check("held_rdata", rd_m, 32'(32'h300 + k));
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    exp_txn += 3;
    @(negedge clk);
    check("held_txn", tc_m, 32'(exp_txn));
    txn("st7", 1'b1, 32'd7, 32'h1, 32'd0, 1'b0, 0);
    // reset while the store to 7 sits in WAIT
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'hAAAA;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_busy", 32'(bz_m), 32'd1);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    exp_txn = 0;
    check("mid_txn", tc_m, 32'd0);
    check("mid_busy0", 32'(bz_m), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_no_resp", 32'(rv_m), 32'd0);
    txn("ld7", 1'b0, 32'd7, 32'd0, 32'h1, 1'b0, 0);
    // LATENCY=1 instance, the LATENCY=2 one held in reset
    rst0 = 1'b1; sel = 1'b1; exp_txn = 0;
    @(negedge clk);
    rst1 = 1'b0;
    check("l1_rst_txn", tc_m, 32'd0);
    for (int k = 0; k < 5; k++) txn("l1_st", 1'b1, 32'(k), vals[k], 32'd0, 1'b0, 0);
    for (int k = 0; k < 5; k++) txn("l1_ld", 1'b0, 32'(k), 32'd0, vals[k], 1'b0, 0);
    txn("l1_oor", 1'b0, 32'd70000, 32'd0, 32'd0, 1'b1, 0);
    check("l1_txn", tc_m, 32'd11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
